data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Shares the single stage-4 data memory port between the pipeline load/store path and a secondary DMA/debug requester.
- The pipeline has default priority. A starvation counter forces a DMA grant after MAX_STALL consecutive lost cycles; during that forced cycle the pipeline is stalled.
- The block sits between stage 4 and the data memory top. It drives that block's valid, store-type, load_type, address and write-value inputs, and returns read data to the winner. DMA read data is returned registered.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data (word).
- MAX_STALL, 4, consecutive cycles the DMA may lose to the pipeline before it is forced to win. Legal range is 1..15.
- WORD_LOAD_TYPE, 3'b010, load_type code driven to memory for DMA accesses (full word, funct3 LW/SW).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_valid  in  1  stage 4 requests a memory access this cycle.
- pipe_store  in  1  1 = store, 0 = load.
- pipe_load_type  in  3  funct3 byte/half/word code.
- pipe_addr  in  DATA_WIDTH  byte address.
- pipe_wdata  in  DATA_WIDTH  rs2 value.
- pipe_stall  out  1  stage 4 must hold its request this cycle (combinational).
- pipe_rdata  out  DATA_WIDTH  mem_rdata passthrough.
- dma_req  in  1  DMA requests an access. Must hold req, write, addr and wdata stable until granted.
- dma_write  in  1  1 = word store, 0 = word load.
- dma_addr  in  DATA_WIDTH  word-aligned address.
- dma_wdata  in  DATA_WIDTH  store data.
- dma_gnt  out  1  access performed this cycle (combinational).
- dma_rvalid  out  1  registered, 1-cycle pulse carrying read data.
- dma_rdata  out  DATA_WIDTH  registered read data.
- mem_valid  out  1  memory access enable.
- mem_store  out  1  store select to memory.
- mem_load_type  out  3  access width to memory.
- mem_addr  out  DATA_WIDTH  access address.
- mem_wdata  out  DATA_WIDTH  write value.
- mem_rdata  in  DATA_WIDTH  memory read value, combinational in the same cycle as mem_addr.

Behaviour:
- FSM states are PIPE_PRI and DMA_PRI. Reset puts the FSM in PIPE_PRI with starve_cnt=0, dma_rvalid=0 and dma_rdata=0.
- Grant in PIPE_PRI:
  - dma_gnt = dma_req & ~pipe_valid.
  - pipe_stall = 0.
- Grant in DMA_PRI:
  - dma_gnt = dma_req.
  - pipe_stall = pipe_valid & dma_req.
- Memory mux when dma_gnt=1:
  - mem_valid=1, mem_store=dma_write, mem_load_type=WORD_LOAD_TYPE, mem_addr=dma_addr, mem_wdata=dma_wdata.
- Memory mux when dma_gnt=0:
  - mem_valid=pipe_valid, mem_store=pipe_store, mem_load_type=pipe_load_type, mem_addr=pipe_addr, mem_wdata=pipe_wdata.
  - These pipe values are driven even when pipe_valid=0.
- pipe_rdata = mem_rdata always. The pipeline ignores it while stalled.
- starve_cnt is 4 bits. On each clock edge, in priority order:
  - dma_gnt → 0.
  - dma_req & pipe_valid & ~dma_gnt → starve_cnt+1, saturating at MAX_STALL.
  - ~dma_req → 0.
- Transitions:
  - PIPE_PRI→DMA_PRI when next starve_cnt == MAX_STALL.
  - DMA_PRI→PIPE_PRI on the edge where dma_gnt=1.
  - DMA_PRI with dma_req dropped (protocol violation) → PIPE_PRI, starve_cnt=0.
- The forced DMA win therefore occurs in the cycle after the MAX_STALL-th lost cycle: exactly one DMA grant, then the pipeline regains priority.
- Read return: at the edge closing a cycle with dma_gnt & ~dma_write, dma_rvalid←1 and dma_rdata←mem_rdata. Otherwise dma_rvalid←0 and dma_rdata holds its value. Latency is 1 cycle from grant.
- Back-to-back DMA reads on an idle pipeline give a dma_rvalid pulse every cycle, each carrying the correct data.
- Simultaneous pipe_valid and dma_req in PIPE_PRI: the pipeline wins and the counter increments.
- Asynchronous reset mid-operation: FSM, counter and dma_rvalid clear immediately. A grant in flight is lost and the DMA must re-request.
- Stores are committed by memory on the clock edge under mem_valid & mem_store. The arbiter adds no write latency.

Test Plan:
1. Idle pipe; dma_req=1, dma_write=1, addr=0x40, wdata=0xDEADBEEF. Expect dma_gnt=1 that cycle and mem_store=1, mem_load_type=3'b010. Then a DMA read of 0x40 gives dma_rvalid=1 and dma_rdata=0xDEADBEEF one cycle later.
2. pipe_valid=1 continuously with dma_req=1 and MAX_STALL=4. Expect pipe served cycles 0-3, dma_gnt=1 with pipe_stall=1 in cycle 4, pipe served cycles 5-8, and the forced grant again in cycle 9.
3. pipe_valid=1 and dma_req pulsed high 2 cycles, low 1, high again. Expect the counter to reset on the low cycle, so the forced grant lands 4 lost cycles after the re-request.
4. Pipe load (lb, load_type 3'b000) at 0x41 concurrent with a granted-idle DMA. Expect mem_addr=0x41 and pipe_rdata=mem_rdata, with no dma_rvalid.
5. Assert reset while in DMA_PRI with a read granted. Expect dma_rvalid=0, pipe_stall=0 and starve_cnt=0 at once. After release the pipeline wins a simultaneous request.
6. DMA read back-to-back 3 cycles on an idle pipe at 0x0, 0x4, 0x8. Expect dma_rvalid high for 3 consecutive cycles with the data in order.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - shares the stage-4 data memory port between the pipeline and a DMA/debug requester
module data_memory_arbiter #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          MAX_STALL      = 4,
    parameter logic [2:0]  WORD_LOAD_TYPE = 3'b010
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_valid,
    input  logic                  pipe_store,
    input  logic [2:0]            pipe_load_type,
    input  logic [DATA_WIDTH-1:0] pipe_addr,
    input  logic [DATA_WIDTH-1:0] pipe_wdata,
    output logic                  pipe_stall,
    output logic [DATA_WIDTH-1:0] pipe_rdata,
    input  logic                  dma_req,
    input  logic                  dma_write,
    input  logic [DATA_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mem_valid,
    output logic                  mem_store,
    output logic [2:0]            mem_load_type,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_STALL);

    typedef enum logic {PIPE_PRI, DMA_PRI} state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic [3:0] starve_next;

    always_comb begin
        dma_gnt    = 1'b0;
        pipe_stall = 1'b0;
        if (state == DMA_PRI) begin
            dma_gnt    = dma_req;
            pipe_stall = pipe_valid & dma_req;
        end else begin
            dma_gnt    = dma_req & ~pipe_valid;
        end
    end

    // Pipe fields drive the port even when idle so stage 4 sees a stable address.
    always_comb begin
        if (dma_gnt) begin
            mem_valid     = 1'b1;
            mem_store     = dma_write;
            mem_load_type = WORD_LOAD_TYPE;
            mem_addr      = dma_addr;
            mem_wdata     = dma_wdata;
        end else begin
            mem_valid     = pipe_valid;
            mem_store     = pipe_store;
            mem_load_type = pipe_load_type;
            mem_addr      = pipe_addr;
            mem_wdata     = pipe_wdata;
        end
    end

    assign pipe_rdata = mem_rdata;

    always_comb begin
        starve_next = starve_cnt;
        if (dma_gnt) begin
            starve_next = 4'd0;
        end else if (dma_req && pipe_valid) begin
            starve_next = (starve_cnt >= MAX_CNT) ? MAX_CNT : starve_cnt + 4'd1;
        end else if (!dma_req) begin
            starve_next = 4'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= PIPE_PRI;
            starve_cnt <= 4'd0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            starve_cnt <= starve_next;
            case (state)
                PIPE_PRI: if (starve_next == MAX_CNT) state <= DMA_PRI;
                // Either the forced grant happened or the requester dropped out.
                DMA_PRI:  state <= PIPE_PRI;
                default:  state <= PIPE_PRI;
            endcase
            if (dma_gnt && !dma_write) begin
                dma_rvalid <= 1'b1;
                dma_rdata  <= mem_rdata;
            end else begin
                dma_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed-vector bench for data_memory_arbiter
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        pipe_valid, pipe_store;
    logic [2:0]  pipe_load_type;
    logic [31:0] pipe_addr, pipe_wdata;
    logic        pipe_stall;
    logic [31:0] pipe_rdata;
    logic        dma_req, dma_write;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_valid, mem_store;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem_array [0:63];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign mem_rdata = mem_array[mem_addr[7:2]];
    always @(posedge clock) if (mem_valid && mem_store) mem_array[mem_addr[7:2]] <= mem_wdata;

    data_memory_arbiter #(.DATA_WIDTH(32), .MAX_STALL(4), .WORD_LOAD_TYPE(3'b010)) dut (
        .clock(clock), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_store(pipe_store), .pipe_load_type(pipe_load_type),
        .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_valid(mem_valid), .mem_store(mem_store), .mem_load_type(mem_load_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pipe(input logic v, input logic st, input logic [2:0] lt, input logic [31:0] a);
        pipe_valid = v; pipe_store = st; pipe_load_type = lt; pipe_addr = a; pipe_wdata = 32'h0BAD_F00D;
    endtask

    task automatic set_dma(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        dma_req = r; dma_write = w; dma_addr = a; dma_wdata = d;
    endtask

    logic [7:0] t3_req;
    logic [7:0] t3_gnt;
    logic [31:0] rd_addr [3];
    logic [31:0] rd_data [3];

    initial begin
        reset = 1'b1;
        set_pipe(0, 0, 3'b000, 32'h0);
        set_dma(0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_rdata", dma_rdata, 32'd0);
        chk("rst_cnt", 32'(dut.starve_cnt), 32'd0);
        reset = 1'b0;
        next_cycle();

        // 1: DMA word store then read-back on an idle pipe
        set_dma(1, 1, 32'h40, 32'hDEADBEEF);
        @(negedge clock);
        chk("t1_wr_gnt", 32'(dma_gnt), 32'd1);
        chk("t1_wr_store", 32'(mem_store), 32'd1);
        chk("t1_wr_lt", 32'(mem_load_type), 32'd2);
        chk("t1_wr_addr", mem_addr, 32'h40);
        chk("t1_wr_data", mem_wdata, 32'hDEADBEEF);
        next_cycle();
        chk("t1_wr_norv", 32'(dma_rvalid), 32'd0);
        set_dma(1, 0, 32'h40, 32'h0);
        @(negedge clock);
        chk("t1_rd_gnt", 32'(dma_gnt), 32'd1);
        chk("t1_rd_store", 32'(mem_store), 32'd0);
        next_cycle();
        set_dma(0, 0, 32'h0, 32'h0);
        chk("t1_rvalid", 32'(dma_rvalid), 32'd1);
        chk("t1_rdata", dma_rdata, 32'hDEADBEEF);
        next_cycle();
        chk("t1_rv_drop", 32'(dma_rvalid), 32'd0);
        chk("t1_rd_hold", dma_rdata, 32'hDEADBEEF);

        // 2: continuous contention, forced grant in cycles 4 and 9
        set_pipe(1, 0, 3'b010, 32'h80);
        set_dma(1, 0, 32'h40, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("t2_gnt_c%0d", i), 32'(dma_gnt), (i == 4 || i == 9) ? 32'd1 : 32'd0);
            chk($sformatf("t2_stall_c%0d", i), 32'(pipe_stall), (i == 4 || i == 9) ? 32'd1 : 32'd0);
            next_cycle();
        end
        set_dma(0, 0, 32'h0, 32'h0);
        next_cycle();

        // 3: request drop clears the counter; forced grant 4 lost cycles after re-request
        t3_req = 8'b1111_1011;
        t3_gnt = 8'b1000_0000;
        for (int i = 0; i < 8; i++) begin
            set_dma(t3_req[i], 0, 32'h40, 32'h0);
            @(negedge clock);
            chk($sformatf("t3_gnt_c%0d", i), 32'(dma_gnt), 32'(t3_gnt[i]));
            next_cycle();
        end
        set_dma(0, 0, 32'h0, 32'h0);

        // 4: pipe byte load with DMA idle
        set_pipe(1, 0, 3'b000, 32'h41);
        @(negedge clock);
        chk("t4_addr", mem_addr, 32'h41);
        chk("t4_lt", 32'(mem_load_type), 32'd0);
        chk("t4_rdata", pipe_rdata, 32'hDEADBEEF);
        chk("t4_gnt", 32'(dma_gnt), 32'd0);
        next_cycle();
        chk("t4_norv", 32'(dma_rvalid), 32'd0);

        // 5: reset while a forced DMA read is granted
        set_pipe(1, 0, 3'b010, 32'h80);
        set_dma(1, 0, 32'h40, 32'h0);
        repeat (4) next_cycle();
        @(negedge clock);
        chk("t5_pre_stall", 32'(pipe_stall), 32'd1);
        chk("t5_pre_gnt", 32'(dma_gnt), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t5_stall", 32'(pipe_stall), 32'd0);
        chk("t5_gnt", 32'(dma_gnt), 32'd0);
        chk("t5_cnt", 32'(dut.starve_cnt), 32'd0);
        chk("t5_rvalid", 32'(dma_rvalid), 32'd0);
        next_cycle();
        chk("t5_rv_hold", 32'(dma_rvalid), 32'd0);
        reset = 1'b0;
        #1;
        @(negedge clock);
        chk("t5_post_gnt", 32'(dma_gnt), 32'd0);
        chk("t5_post_addr", mem_addr, 32'h80);
        next_cycle();
        set_pipe(0, 0, 3'b000, 32'h0);
        set_dma(1, 0, 32'h40, 32'h0);
        next_cycle();
        chk("t5b_rvalid", 32'(dma_rvalid), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t5b_rv_clr", 32'(dma_rvalid), 32'd0);
        chk("t5b_rd_clr", dma_rdata, 32'd0);
        set_dma(0, 0, 32'h0, 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // 6: seed three words, then back-to-back DMA reads
        rd_addr[0] = 32'h0; rd_addr[1] = 32'h4; rd_addr[2] = 32'h8;
        rd_data[0] = 32'h1111_1111; rd_data[1] = 32'h2222_2222; rd_data[2] = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            set_dma(1, 1, rd_addr[i], rd_data[i]);
            @(negedge clock);
            chk($sformatf("t6_wr_gnt%0d", i), 32'(dma_gnt), 32'd1);
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            set_dma(1, 0, rd_addr[i], 32'h0);
            next_cycle();
            chk($sformatf("t6_rvalid%0d", i), 32'(dma_rvalid), 32'd1);
            chk($sformatf("t6_rdata%0d", i), dma_rdata, rd_data[i]);
        end
        set_dma(0, 0, 32'h0, 32'h0);
        next_cycle();
        chk("t6_rv_end", 32'(dma_rvalid), 32'd0);
        chk("t6_rd_hold", dma_rdata, 32'h3333_3333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
